// File: rtl/unidade_controle.sv
// Moore control unit for the memory game: sequences display, player entry checking
// and RAM writes of new colours through the fluxo_dados command inputs.
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fim_jogo,
  input  logic       timeout,
  input  logic       timeout_led,
  input  logic       timeout_habilitado,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_limite,
  output logic       conta_limite,
  output logic       zeraR,
  output logic       registrarR,
  output logic       zera_s_timeout,
  output logic       enable_timeout,
  output logic       zera_s_led,
  output logic       enable_led,
  output logic       zera_modo,
  output logic       registra_modo,
  output logic       conf_leds,
  output logic       registra_jogada,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [4:0] db_estado
);

  typedef enum logic [4:0] {
    INICIAL         = 5'h00,
    PREPARACAO      = 5'h01,
    MOSTRA          = 5'h02,
    APAGA_LED       = 5'h03,
    PROXIMO_LED     = 5'h04,
    FIM_MOSTRA      = 5'h05,
    ESPERA_JOGADA   = 5'h06,
    REGISTRA        = 5'h07,
    COMPARACAO      = 5'h08,
    PROXIMA_JOGADA  = 5'h09,
    PREPARA_ESCRITA = 5'h0A,
    ESPERA_ESCRITA  = 5'h0B,
    ESCREVE         = 5'h0C,
    PROXIMA_RODADA  = 5'h0D,
    FIM_ACERTOU     = 5'h1C,
    FIM_ERROU       = 5'h1D,
    FIM_TIMEOUT     = 5'h1E
  } estado_t;

  typedef struct packed {
    logic zera_endereco;
    logic conta_endereco;
    logic zera_limite;
    logic conta_limite;
    logic zeraR;
    logic registrarR;
    logic zera_s_timeout;
    logic enable_timeout;
    logic zera_s_led;
    logic enable_led;
    logic zera_modo;
    logic registra_modo;
    logic conf_leds;
    logic registra_jogada;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  estado_t r_estado;
  estado_t w_prox;
  saidas_t r_saidas;

  // Outputs are decoded from the state being entered and registered alongside it,
  // so they always equal the decode of r_estado without any combinational path.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zera_endereco = 1'b1; s.zera_limite = 1'b1; s.zeraR = 1'b1;
        s.zera_s_timeout = 1'b1; s.zera_s_led = 1'b1; s.registra_modo = 1'b1;
      end
      MOSTRA:          begin s.conf_leds = 1'b1; s.enable_led = 1'b1; end
      APAGA_LED:       s.zera_s_led = 1'b1;
      PROXIMO_LED:     s.conta_endereco = 1'b1;
      FIM_MOSTRA:      begin s.zera_endereco = 1'b1; s.zera_s_timeout = 1'b1; end
      ESPERA_JOGADA:   s.enable_timeout = 1'b1;
      REGISTRA:        begin s.registrarR = 1'b1; s.zera_s_timeout = 1'b1; end
      COMPARACAO:      s = '0;
      PROXIMA_JOGADA:  s.conta_endereco = 1'b1;
      PREPARA_ESCRITA: begin
        s.conta_endereco = 1'b1; s.conta_limite = 1'b1; s.zera_s_timeout = 1'b1;
      end
      ESPERA_ESCRITA:  s.enable_timeout = 1'b1;
      ESCREVE:         begin s.registra_jogada = 1'b1; s.registrarR = 1'b1; end
      PROXIMA_RODADA:  begin
        s.zera_endereco = 1'b1; s.zera_s_led = 1'b1; s.zera_s_timeout = 1'b1;
      end
      FIM_ACERTOU:     begin s.pronto = 1'b1; s.ganhou = 1'b1; end
      FIM_ERROU:       begin s.pronto = 1'b1; s.perdeu = 1'b1; end
      FIM_TIMEOUT:     begin s.pronto = 1'b1; s.perdeu = 1'b1; s.db_timeout = 1'b1; end
      default: begin
        s.zera_endereco = 1'b1; s.zera_limite = 1'b1; s.zeraR = 1'b1;
        s.zera_s_timeout = 1'b1; s.zera_s_led = 1'b1; s.zera_modo = 1'b1;
      end
    endcase
    return s;
  endfunction

  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:         w_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:      w_prox = MOSTRA;
      MOSTRA:          w_prox = timeout_led ? APAGA_LED : MOSTRA;
      APAGA_LED:       w_prox = enderecoIgualLimite ? FIM_MOSTRA : PROXIMO_LED;
      PROXIMO_LED:     w_prox = MOSTRA;
      FIM_MOSTRA:      w_prox = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita)                       w_prox = REGISTRA;
        else if (timeout && timeout_habilitado) w_prox = FIM_TIMEOUT;
        else                                    w_prox = ESPERA_JOGADA;
      end
      REGISTRA:        w_prox = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                    w_prox = FIM_ERROU;
        else if (!enderecoIgualLimite) w_prox = PROXIMA_JOGADA;
        else if (fim_jogo)             w_prox = FIM_ACERTOU;
        else                           w_prox = PREPARA_ESCRITA;
      end
      PROXIMA_JOGADA:  w_prox = ESPERA_JOGADA;
      PREPARA_ESCRITA: w_prox = ESPERA_ESCRITA;
      ESPERA_ESCRITA: begin
        if (jogada_feita)                       w_prox = ESCREVE;
        else if (timeout && timeout_habilitado) w_prox = FIM_TIMEOUT;
        else                                    w_prox = ESPERA_ESCRITA;
      end
      ESCREVE:         w_prox = PROXIMA_RODADA;
      PROXIMA_RODADA:  w_prox = MOSTRA;
      FIM_ACERTOU:     w_prox = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:       w_prox = iniciar ? PREPARACAO : FIM_ERROU;
      FIM_TIMEOUT:     w_prox = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:         w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_saidas <= decodifica(INICIAL);
    end else begin
      r_estado <= w_prox;
      r_saidas <= decodifica(w_prox);
    end
  end

  assign zera_endereco   = r_saidas.zera_endereco;
  assign conta_endereco  = r_saidas.conta_endereco;
  assign zera_limite     = r_saidas.zera_limite;
  assign conta_limite    = r_saidas.conta_limite;
  assign zeraR           = r_saidas.zeraR;
  assign registrarR      = r_saidas.registrarR;
  assign zera_s_timeout  = r_saidas.zera_s_timeout;
  assign enable_timeout  = r_saidas.enable_timeout;
  assign zera_s_led      = r_saidas.zera_s_led;
  assign enable_led      = r_saidas.enable_led;
  assign zera_modo       = r_saidas.zera_modo;
  assign registra_modo   = r_saidas.registra_modo;
  assign conf_leds       = r_saidas.conf_leds;
  assign registra_jogada = r_saidas.registra_jogada;
  assign pronto          = r_saidas.pronto;
  assign ganhou          = r_saidas.ganhou;
  assign perdeu          = r_saidas.perdeu;
  assign db_timeout      = r_saidas.db_timeout;
  assign db_estado       = r_estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: status flags are driven directly and each
// edge's expected state/output word is queued, then popped and checked after the edge.
module tb_unidade_controle;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0, jogada_feita = 1'b0, igual = 1'b0, enderecoIgualLimite = 1'b0;
  logic fim_jogo = 1'b0, timeout = 1'b0, timeout_led = 1'b0, timeout_habilitado = 1'b0;
  logic zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR;
  logic zera_s_timeout, enable_timeout, zera_s_led, enable_led, zera_modo, registra_modo;
  logic conf_leds, registra_jogada, pronto, ganhou, perdeu, db_timeout;
  logic [4:0] db_estado;

  int checks = 0;
  int errors = 0;
  logic [22:0] exp_q[$];

  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .enderecoIgualLimite(enderecoIgualLimite), .fim_jogo(fim_jogo),
    .timeout(timeout), .timeout_led(timeout_led), .timeout_habilitado(timeout_habilitado),
    .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
    .zera_limite(zera_limite), .conta_limite(conta_limite), .zeraR(zeraR),
    .registrarR(registrarR), .zera_s_timeout(zera_s_timeout),
    .enable_timeout(enable_timeout), .zera_s_led(zera_s_led), .enable_led(enable_led),
    .zera_modo(zera_modo), .registra_modo(registra_modo), .conf_leds(conf_leds),
    .registra_jogada(registra_jogada), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Bit order (MSB first): zera_end conta_end zera_lim conta_lim zeraR registrarR
  // zera_s_to en_to zera_s_led en_led zera_modo reg_modo conf_leds reg_jog pronto ganhou perdeu db_to
  function automatic logic [17:0] saidas_esperadas(input logic [4:0] e);
    case (e)
      5'h00: return 18'b1_0_1_0_1_0_1_0_1_0_1_0_0_0_0_0_0_0;
      5'h01: return 18'b1_0_1_0_1_0_1_0_1_0_0_1_0_0_0_0_0_0;
      5'h02: return 18'b0_0_0_0_0_0_0_0_0_1_0_0_1_0_0_0_0_0;
      5'h03: return 18'b0_0_0_0_0_0_0_0_1_0_0_0_0_0_0_0_0_0;
      5'h04: return 18'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
      5'h05: return 18'b1_0_0_0_0_0_1_0_0_0_0_0_0_0_0_0_0_0;
      5'h06: return 18'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_0_0_0_0;
      5'h07: return 18'b0_0_0_0_0_1_1_0_0_0_0_0_0_0_0_0_0_0;
      5'h08: return 18'b0;
      5'h09: return 18'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
      5'h0A: return 18'b0_1_0_1_0_0_1_0_0_0_0_0_0_0_0_0_0_0;
      5'h0B: return 18'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_0_0_0_0;
      5'h0C: return 18'b0_0_0_0_0_1_0_0_0_0_0_0_0_1_0_0_0_0;
      5'h0D: return 18'b1_0_0_0_0_0_1_0_1_0_0_0_0_0_0_0_0_0;
      5'h1C: return 18'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1_1_0_0;
      5'h1D: return 18'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1_0_1_0;
      5'h1E: return 18'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1_0_1_1;
      default: return 18'h3FFFF;
    endcase
  endfunction

  // Drive nothing new; queue the expectation, clock once, then check after the edge.
  task automatic step(input logic [4:0] exp_estado, input string tag);
    logic [22:0] exp_w;
    logic [17:0] obs_s;
    exp_q.push_back({exp_estado, saidas_esperadas(exp_estado)});
    @(posedge clock);
    #1;
    exp_w = exp_q.pop_front();
    obs_s = {zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR,
             zera_s_timeout, enable_timeout, zera_s_led, enable_led, zera_modo,
             registra_modo, conf_leds, registra_jogada, pronto, ganhou, perdeu, db_timeout};
    checks++;
    assert (db_estado === exp_w[22:18]) else begin
      errors++;
      $error("FAIL %s state: observed %h expected %h", tag, db_estado, exp_w[22:18]);
    end
    checks++;
    assert (obs_s === exp_w[17:0]) else begin
      errors++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs_s, exp_w[17:0]);
    end
  endtask

  task automatic mostra_ultimo_ate_espera();
    timeout_led = 1'b1; enderecoIgualLimite = 1'b1;
    step(5'h03, "mostra_fim");
    timeout_led = 1'b0;
    step(5'h05, "fim_mostra");
    step(5'h06, "espera_jogada");
  endtask

  initial begin
    step(5'h00, "reset");
    reset = 1'b0;
    step(5'h00, "idle");
    iniciar = 1'b1;
    step(5'h01, "preparacao");
    iniciar = 1'b0;
    step(5'h02, "mostra");
    step(5'h02, "mostra_hold");
    mostra_ultimo_ate_espera();

    // Round 1: single correct entry, then a write with simultaneous jogada/timeout.
    timeout_habilitado = 1'b1;
    jogada_feita = 1'b1;
    step(5'h07, "registra");
    jogada_feita = 1'b0; igual = 1'b1;
    step(5'h08, "comparacao");
    step(5'h0A, "prepara_escrita");
    step(5'h0B, "espera_escrita");
    step(5'h0B, "espera_escrita_hold");
    jogada_feita = 1'b1; timeout = 1'b1;
    step(5'h0C, "escreve_simult");
    jogada_feita = 1'b0; timeout = 1'b0;
    step(5'h0D, "proxima_rodada");
    step(5'h02, "mostra_r2");

    // Round 2: two LEDs shown, first entry correct, second wrong.
    timeout_led = 1'b1; enderecoIgualLimite = 1'b0;
    step(5'h03, "apaga_led");
    step(5'h04, "proximo_led");
    step(5'h02, "mostra_led2");
    mostra_ultimo_ate_espera();
    jogada_feita = 1'b1;
    step(5'h07, "registra_r2a");
    jogada_feita = 1'b0; enderecoIgualLimite = 1'b0; igual = 1'b1;
    step(5'h08, "comparacao_r2a");
    step(5'h09, "proxima_jogada");
    step(5'h06, "espera_r2b");
    jogada_feita = 1'b1;
    step(5'h07, "registra_r2b");
    jogada_feita = 1'b0; igual = 1'b0;
    step(5'h08, "comparacao_r2b");
    step(5'h1D, "fim_errou");
    step(5'h1D, "fim_errou_hold");
    iniciar = 1'b1;
    step(5'h01, "restart_errou");
    iniciar = 1'b0;
    step(5'h02, "mostra_g2");
    mostra_ultimo_ate_espera();

    // Timeout disabled: stays waiting; then enabled: times out.
    timeout_habilitado = 1'b0; timeout = 1'b1;
    for (int i = 0; i < 8; i++) step(5'h06, "timeout_off");
    timeout_habilitado = 1'b1;
    step(5'h1E, "fim_timeout");
    timeout = 1'b0;
    step(5'h1E, "fim_timeout_hold");
    iniciar = 1'b1;
    step(5'h01, "restart_timeout");
    iniciar = 1'b0;
    step(5'h02, "mostra_g3");
    mostra_ultimo_ate_espera();

    // Final round correct: win.
    jogada_feita = 1'b1;
    step(5'h07, "registra_win");
    jogada_feita = 1'b0; igual = 1'b1; enderecoIgualLimite = 1'b1; fim_jogo = 1'b1;
    step(5'h08, "comparacao_win");
    step(5'h1C, "fim_acertou");
    fim_jogo = 1'b0;
    step(5'h1C, "fim_acertou_hold");

    // Reset while waiting for the write beats a pending jogada.
    iniciar = 1'b1;
    step(5'h01, "restart_win");
    iniciar = 1'b0;
    step(5'h02, "mostra_g4");
    mostra_ultimo_ate_espera();
    jogada_feita = 1'b1;
    step(5'h07, "registra_g4");
    jogada_feita = 1'b0; igual = 1'b1; enderecoIgualLimite = 1'b1;
    step(5'h08, "comparacao_g4");
    step(5'h0A, "prepara_escrita_g4");
    step(5'h0B, "espera_escrita_g4");
    reset = 1'b1; jogada_feita = 1'b1;
    step(5'h00, "reset_escrita");
    reset = 1'b0; jogada_feita = 1'b0;
    step(5'h00, "idle_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
